// File: rtl/seven_seg_scan_decoder.sv
// Passive monitor for a four-digit multiplexed seven-segment bus: rebuilds the shown hex digits
// and decimal points from the pins, pulses on complete frames and illegal captures, and flags a stalled scan.
module seven_seg_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        an3,
  input  logic        an2,
  input  logic        an1,
  input  logic        an0,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        e,
  input  logic        f,
  input  logic        g,
  input  logic        dp,
  output logic [15:0] digits,
  output logic [3:0]  dp_mask,
  output logic        frame_valid,
  output logic        bad_pattern,
  output logic        stale
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SettleMax = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] SettleHit = SW'(SETTLE_CYCLES - 2);
  localparam logic [TW-1:0] TmoMax    = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TmoHit    = TW'(TIMEOUT_CYCLES - 1);

  logic [11:0]   w_pins;
  logic [11:0]   r_sync1, r_sync2, r_prev;
  logic [SW-1:0] r_stab_cnt;
  logic [TW-1:0] r_tmo_cnt;
  logic [3:0]    r_seen;

  logic          w_same, w_capture;
  logic [3:0]    w_an_low;
  logic [6:0]    w_seg_lit;
  logic          w_dp_lit;
  logic          w_blank, w_one_hot;
  logic [3:0]    w_nib;
  logic          w_seg_ok;
  logic          w_valid, w_bad, w_frame, w_tmo_hit;
  logic [3:0]    w_seen_nxt;
  logic [15:0]   w_digits_nxt;
  logic [3:0]    w_dp_nxt;

  assign w_pins = {an3, an2, an1, an0, a, b, c, d, e, f, g, dp};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1    <= '1;
      r_sync2    <= '1;
      r_prev     <= '1;
      r_stab_cnt <= '0;
    end else begin
      r_sync1 <= w_pins;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (!w_same)                  r_stab_cnt <= '0;
      else if (r_stab_cnt < SettleMax) r_stab_cnt <= r_stab_cnt + SW'(1);
    end
  end

  // Fires once per stable interval, when the count steps onto SETTLE_CYCLES-1.
  assign w_same    = (r_sync2 == r_prev);
  assign w_capture = w_same && (r_stab_cnt == SettleHit);

  assign w_an_low  = ~r_sync2[11:8];
  assign w_seg_lit = ~r_sync2[7:1];
  assign w_dp_lit  = ~r_sync2[0];
  assign w_blank   = (w_an_low == 4'h0);
  assign w_one_hot = !w_blank && ((w_an_low & (w_an_low - 4'd1)) == 4'h0);

  always_comb begin
    w_nib    = 4'h0;
    w_seg_ok = 1'b1;
    case (w_seg_lit)
      7'b1111110: w_nib = 4'h0;
      7'b0110000: w_nib = 4'h1;
      7'b1101101: w_nib = 4'h2;
      7'b1111001: w_nib = 4'h3;
      7'b0110011: w_nib = 4'h4;
      7'b1011011: w_nib = 4'h5;
      7'b1011111: w_nib = 4'h6;
      7'b1110000: w_nib = 4'h7;
      7'b1111111: w_nib = 4'h8;
      7'b1111011: w_nib = 4'h9;
      7'b1110111: w_nib = 4'hA;
      7'b0011111: w_nib = 4'hB;
      7'b1001110: w_nib = 4'hC;
      7'b0111101: w_nib = 4'hD;
      7'b1001111: w_nib = 4'hE;
      7'b1000111: w_nib = 4'hF;
      default:    w_seg_ok = 1'b0;
    endcase
  end

  assign w_valid    = w_capture && w_one_hot && w_seg_ok;
  assign w_bad      = w_capture && !w_blank && !(w_one_hot && w_seg_ok);
  assign w_seen_nxt = r_seen | w_an_low;
  assign w_frame    = w_valid && (w_seen_nxt == 4'hF);
  assign w_tmo_hit  = !w_valid && (r_tmo_cnt == TmoHit);

  always_comb begin
    w_digits_nxt = digits;
    w_dp_nxt     = dp_mask;
    for (int k = 0; k < 4; k++) begin
      if (w_an_low[k]) begin
        w_digits_nxt[4*k +: 4] = w_nib;
        w_dp_nxt[k]            = w_dp_lit;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digits      <= 16'h0000;
      dp_mask     <= 4'h0;
      frame_valid <= 1'b0;
      bad_pattern <= 1'b0;
      stale       <= 1'b1;
      r_seen      <= 4'h0;
      r_tmo_cnt   <= '0;
    end else begin
      frame_valid <= w_frame;
      bad_pattern <= w_bad;
      if (w_valid) begin
        digits    <= w_digits_nxt;
        dp_mask   <= w_dp_nxt;
        r_seen    <= w_frame ? 4'h0 : w_seen_nxt;
        r_tmo_cnt <= '0;
        stale     <= 1'b0;
      end else begin
        if (r_tmo_cnt < TmoMax) r_tmo_cnt <= r_tmo_cnt + TW'(1);
        if (w_tmo_hit) begin
          stale  <= 1'b1;
          r_seen <= 4'h0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Bench for seven_seg_scan_decoder: directed scenarios plus random scan traffic, checked every
// cycle against a pin-history model and pinned by literal expectations.
module tb_seven_seg_scan_decoder;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] an_pin = 4'hF;
  logic [6:0] seg_pin = 7'h7F;
  logic dp_pin = 1'b1;

  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic        frame_valid, bad_pattern, stale;

  int total = 0;
  int bad = 0;
  int fv_cnt = 0;
  int bad_cnt = 0;

  always #5 clk = ~clk;

  seven_seg_scan_decoder #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .an3        (an_pin[3]),
    .an2        (an_pin[2]),
    .an1        (an_pin[1]),
    .an0        (an_pin[0]),
    .a          (seg_pin[6]),
    .b          (seg_pin[5]),
    .c          (seg_pin[4]),
    .d          (seg_pin[3]),
    .e          (seg_pin[2]),
    .f          (seg_pin[1]),
    .g          (seg_pin[0]),
    .dp         (dp_pin),
    .digits     (digits),
    .dp_mask    (dp_mask),
    .frame_valid(frame_valid),
    .bad_pattern(bad_pattern),
    .stale      (stale)
  );

  // Lit segments abcdefg (active-high) for each hex value.
  logic [6:0] seg_tab [16];
  initial seg_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  function automatic int lookup(input logic [6:0] lit);
    for (int i = 0; i < 16; i++) if (seg_tab[i] == lit) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the monitor sees the pins two edges late; a capture is the SETTLE-th
  // consecutive cycle of an unchanged delayed vector.
  logic [11:0] hist [$];
  logic [11:0] s_last;
  int          run_len;
  int          tcnt;
  logic [3:0]  m_seen;
  logic [15:0] m_digits;
  logic [3:0]  m_dp;
  logic        m_fv, m_bad, m_stale;
  logic        model_ready = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist = {};
      hist.push_back(12'hFFF);
      hist.push_back(12'hFFF);
      s_last = 12'hFFF; run_len = 1; tcnt = 0; m_seen = 4'h0;
      m_digits = 16'h0; m_dp = 4'h0; m_fv = 1'b0; m_bad = 1'b0; m_stale = 1'b1;
      model_ready = 1'b1;
    end else begin
      logic [11:0] s;
      logic [3:0] low;
      int k, v;
      logic ok;
      hist.push_back({an_pin, seg_pin, dp_pin});
      s = hist.pop_front();
      run_len = (s == s_last) ? run_len + 1 : 1;
      s_last = s;
      m_fv = 1'b0; m_bad = 1'b0; ok = 1'b0; k = 0; v = -1;
      if (run_len == SETTLE) begin
        low = ~s[11:8];
        if ($countones(low) > 1) m_bad = 1'b1;
        else if ($countones(low) == 1) begin
          for (int i = 0; i < 4; i++) if (low[i]) k = i;
          v = lookup(~s[7:1]);
          if (v < 0) m_bad = 1'b1; else ok = 1'b1;
        end
      end
      if (ok) begin
        m_digits[4*k +: 4] = 4'(v);
        m_dp[k] = ~s[0];
        m_seen[k] = 1'b1;
        tcnt = 0;
        m_stale = 1'b0;
        if (m_seen == 4'hF) begin m_fv = 1'b1; m_seen = 4'h0; end
      end else if (tcnt < TIMEOUT) begin
        tcnt++;
        if (tcnt == TIMEOUT) begin m_stale = 1'b1; m_seen = 4'h0; end
      end
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      check("digits", 32'(digits), 32'(m_digits));
      check("dp_mask", 32'(dp_mask), 32'(m_dp));
      check("frame_valid", 32'(frame_valid), 32'(m_fv));
      check("bad_pattern", 32'(bad_pattern), 32'(m_bad));
      check("stale", 32'(stale), 32'(m_stale));
    end
    if (frame_valid) fv_cnt++;
    if (bad_pattern) bad_cnt++;
  end

  task automatic show(input logic [3:0] an_low, input logic [6:0] lit, input logic dpl,
                      input int n);
    an_pin = ~an_low; seg_pin = ~lit; dp_pin = ~dpl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic dig(input int k, input int v, input logic dpl, input int n);
    show(4'(1 << k), seg_tab[v], dpl, n);
  endtask

  task automatic blank(input int n);
    show(4'h0, 7'h00, 1'b0, n);
  endtask

  initial begin
    int f0, b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_dp_mask", 32'(dp_mask), 32'h0);
    check("rst_frame_valid", 32'(frame_valid), 32'h0);
    check("rst_bad_pattern", 32'(bad_pattern), 32'h0);
    check("rst_stale", 32'(stale), 32'h1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Normal frame 1234, dp on an1.
    dig(3, 1, 0, 16); dig(2, 2, 0, 16); dig(1, 3, 1, 16); dig(0, 4, 0, 16); blank(8);
    check("frame_digits", 32'(digits), 32'h1234);
    check("frame_dp", 32'(dp_mask), 32'b0010);
    check("frame_stale", 32'(stale), 32'h0);
    check("frame_count", 32'(fv_cnt), 32'd1);

    // Illegal segments on an1 (only g lit) block the frame until a legal an1 digit.
    b0 = bad_cnt;
    dig(3, 10, 0, 16); dig(2, 11, 0, 16); show(4'b0010, 7'b0000001, 0, 16); dig(0, 12, 0, 16);
    blank(8);
    check("illegal_bad", 32'(bad_cnt - b0), 32'd1);
    check("illegal_noframe", 32'(fv_cnt), 32'd1);
    dig(1, 13, 0, 16); blank(8);
    check("illegal_frame", 32'(fv_cnt), 32'd2);
    check("illegal_digits", 32'(digits), 32'hABDC);

    // Glitch: an2 shows 7 for only 3 cycles.
    b0 = bad_cnt;
    dig(3, 5, 0, 16); dig(2, 7, 0, 3); dig(1, 3, 0, 16); blank(8);
    check("glitch_digits", 32'(digits), 32'h5B3C);
    check("glitch_bad", 32'(bad_cnt - b0), 32'd0);

    // Two anodes low with '8'.
    show(4'b1001, seg_tab[8], 0, 16); blank(4);
    check("multi_bad", 32'(bad_cnt - b0), 32'd1);
    check("multi_digits", 32'(digits), 32'h5B3C);

    // Stall then resume.
    blank(4100);
    check("stall_stale", 32'(stale), 32'h1);
    check("stall_digits", 32'(digits), 32'h5B3C);
    f0 = fv_cnt;
    dig(2, 9, 0, 16);
    check("resume_stale", 32'(stale), 32'h0);
    dig(0, 0, 0, 16); blank(8);
    check("resume_noframe", 32'(fv_cnt - f0), 32'd0);
    dig(3, 14, 0, 16); dig(1, 15, 0, 16); blank(8);
    check("resume_frame", 32'(fv_cnt - f0), 32'd1);
    check("resume_digits", 32'(digits), 32'hE9F0);

    // Random scan traffic, including illegal and multi-anode captures.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] an;
      logic [6:0] lit;
      int r;
      r = int'($urandom_range(0, 9));
      an = (r < 7) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      lit = (r == 3) ? 7'($urandom_range(0, 127)) : seg_tab[$urandom_range(0, 15)];
      show(an, lit, 1'($urandom_range(0, 1)), int'($urandom_range(1, 20)));
    end
    blank(8);

    // Reset mid-frame.
    f0 = fv_cnt;
    dig(3, 1, 0, 16); dig(2, 2, 0, 16);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_digits", 32'(digits), 32'h0);
    check("midrst_stale", 32'(stale), 32'h1);
    rst_n = 1'b1;
    dig(1, 3, 0, 16); dig(0, 4, 0, 16); blank(8);
    check("midrst_noframe", 32'(fv_cnt - f0), 32'd0);
    dig(3, 6, 0, 16); dig(2, 8, 1, 16); blank(8);
    check("midrst_frame", 32'(fv_cnt - f0), 32'd1);
    check("midrst_digits2", 32'(digits), 32'h6834);
    check("midrst_dp", 32'(dp_mask), 32'b0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_decoder.md
# seven_seg_scan_decoder

Passive monitor for the four-digit multiplexed seven-segment bus. It samples the anode strobes and segment lines that the display driver produces and reconstructs the four displayed hex digits and decimal points. It reports a complete frame once every digit position has been captured, and flags illegal patterns and a stalled scan. The block sits alongside the display driver, on its output pins, for self-check and readback.

## Interface
Parameters:
- SETTLE_CYCLES, 4: consecutive identical synchronized samples required before a capture; legal range ≥2.
- TIMEOUT_CYCLES, 4096: cycles without a successful capture before the scan is declared stale; legal range ≥16.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-low reset.
- an3, an2, an1, an0  in  1 each  anode strobes, active-low; an0 is the rightmost digit.
- a, b, c, d, e, f, g  in  1 each  segment lines, active-low (0 means lit).
- dp  in  1  decimal point, active-low.
- digits  out  16  reconstructed digits: [3:0] from an0 through [15:12] from an3.
- dp_mask  out  4  bit k = 1 when the dp was lit while digit k was captured.
- frame_valid  out  1  one-cycle pulse when all four positions have been captured since the last frame.
- bad_pattern  out  1  one-cycle pulse on an illegal capture.
- stale  out  1  level; high when no successful capture has occurred for TIMEOUT_CYCLES.

## Operation
- **Synchronizer.** All 12 inputs pass through a 2-flop synchronizer. Its flops reset to 1, the inactive level. S denotes the 12-bit synchronized vector {an3..an0, a..g, dp}.
- **Stability tracking.**
  - prev holds S from the previous cycle; it resets to all ones.
  - stab_cnt resets to 0 when S ≠ prev and otherwise increments, saturating at SETTLE_CYCLES.
  - A capture event fires exactly once per stable interval: in the cycle where stab_cnt transitions to SETTLE_CYCLES−1 with S = prev. An interval held for N cycles therefore captures if N ≥ SETTLE_CYCLES.
- **Capture classification.** The anode field is checked first.
  - All ones (blank): ignored. No error, no update.
  - Exactly one zero, at position k: the segment field is decoded.
  - Two or more zeros: bad_pattern pulse, no update.
- **Segment decode.** Lit-segment pattern abcdefg, written active-high, maps as follows:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
  - Any other pattern, including all-off, produces a bad_pattern pulse, no update, and seen unchanged.
- **Valid capture.** digits[4k+3:4k] ← nibble; dp_mask[k] ← ~dp; seen[k] ← 1; timeout counter ← 0; stale ← 0.
- **Frame completion.** When a valid capture makes seen = 4'b1111, frame_valid pulses and seen clears to 0 on the same edge. digits and dp_mask hold their values until overwritten.
- **Timeout.** The counter increments each cycle with no valid capture, saturating at TIMEOUT_CYCLES. On reaching TIMEOUT_CYCLES, stale ← 1 and seen ← 0; digits and dp_mask are retained.
- **Simultaneous events.**
  - A valid capture in the same cycle as timeout expiry: the capture wins. The counter resets and stale stays 0.
  - Recapturing a digit already in seen: overwrites the value and keeps seen[k] = 1.
- **Reset.** Asserting reset at any time, including mid-frame, immediately clears digits, dp_mask, seen and all counters; frame_valid = 0, bad_pattern = 0, stale = 1. After release, a full four-digit frame is required before the next frame_valid.

## Timing
- Reset values: digits = 16'h0000, dp_mask = 4'h0, frame_valid = 0, bad_pattern = 0, stale = 1.
- Latency from a pin vector becoming stable to the capture: 2 (synchronizer) + SETTLE_CYCLES−1 cycles. Outputs are registered and update on the following edge, giving 2 + SETTLE_CYCLES cycles total.
- frame_valid is high in exactly the cycle in which the final digit's value first appears on digits.
- bad_pattern is high for one cycle, aligned with the edge on which a valid capture would have updated digits.
- stale rises on the edge where the timeout counter reaches TIMEOUT_CYCLES. It falls on the edge that registers the next valid capture.
- The anode scan has no minimum period beyond SETTLE_CYCLES per digit; there is no maximum other than the timeout.

## Test plan
- **Normal frame.** Scan an3..an0 showing 1, 2, 3, 4, 16 cycles each, dp lit on an1 only → one frame_valid pulse after the an0 capture; digits = 16'h1234, dp_mask = 4'b0010, stale falls after the first capture.
- **Glitch rejection.** With SETTLE_CYCLES = 4, hold an2 = 0 with '7' for 3 cycles between valid digits → no capture, digits[11:8] unchanged, no bad_pattern.
- **Illegal segments.** Hold an1 = 0 with only g lit (pins a..g = 1111110) for 16 cycles → single bad_pattern pulse; seen[1] stays 0; no frame_valid until a legal digit is shown on an1.
- **Multiple anodes.** Hold an3 = an0 = 0 with '8' for 16 cycles → single bad_pattern pulse; digits unchanged.
- **Stall.** Stop the scan (all anodes 1) for 4100 cycles with default TIMEOUT_CYCLES → stale = 1 at cycle 4096 after the last capture, digits retained. Resume the scan → stale = 0 at the first capture; frame_valid only after all four positions are captured.
- **Reset mid-frame.** Capture an3 and an2, pulse reset low for 1 cycle → digits = 0, stale = 1. Scan only an1 and an0 → no frame_valid; complete all four → frame_valid.
